// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder and its controller.
//  - Serial NOR opcode constants
//  - FSM state enum and deferred chip-select-rise actions
package spi_flash_pkg;

  localparam logic [7:0] OpRead     = 8'h03;
  localparam logic [7:0] OpFastRead = 8'h0B;
  localparam logic [7:0] OpPp       = 8'h02;
  localparam logic [7:0] OpWren     = 8'h06;
  localparam logic [7:0] OpWrdi     = 8'h04;
  localparam logic [7:0] OpRdsr     = 8'h05;
  localparam logic [7:0] OpRdid     = 8'h9F;

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StDataRd,
    StDataWr,
    StStatus,
    StId,
    StIgnore
  } state_e;

  // Side effects that only take place when chip select rises.
  typedef enum logic [1:0] {
    ActNone,
    ActWren,
    ActWrdi,
    ActPp
  } act_e;

  // States in which the responder drives MISO.
  function automatic logic is_tx_state(state_e s);
    return s inside {StStatus, StId, StDataRd};
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// SPI pin synchroniser and edge detector.
//  clk, reset        system clock, asynchronous active-high reset
//  spi_cs_n/sck/mosi raw SPI pins
//  cs_n, mosi        synchronised pin levels (2-FF)
//  sck_rise/fall     1-clk pulses on synchronised SCK edges
//  cs_rise/fall      1-clk pulses on synchronised CS edges
module spi_pin_sync (
  input  logic clk,
  input  logic reset,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic cs_n,
  output logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise,
  output logic cs_fall
);

  // Bit 2 is the previous synchronised value, used only for edge detection.
  logic [2:0] cs_q;
  logic [2:0] sck_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q   <= 3'b111;
      sck_q  <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      cs_q   <= {cs_q[1:0], spi_cs_n};
      sck_q  <= {sck_q[1:0], spi_sck};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign cs_n     = cs_q[1];
  assign mosi     = mosi_q[1];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash responder on top of a byte-wide memory port.
//  clk, reset            system clock (>= 8x SCK), asynchronous active-high reset
//  spi_cs_n/sck/mosi     SPI inputs;  spi_miso/spi_miso_oe  SPI output and drive enable
//  mem_addr              memory byte address
//  mem_rd / mem_rdata    1-clk read strobe, data valid on the following clk
//  mem_wr / mem_wdata    1-clk write strobe with data
//  wel, wip              status register bits 1 and 0
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned PROG_CYCLES = 64,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic              wel,
  output logic              wip
);

  localparam int unsigned     WipW    = $clog2(PROG_CYCLES + 1);
  localparam logic [WipW-1:0] WipLoad = WipW'(PROG_CYCLES - 1);

  logic cs_n_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall;

  spi_pin_sync u_pin_sync (
    .clk      (clk),
    .reset    (reset),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .cs_n     (cs_n_s),
    .mosi     (mosi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  state_e            state_q, state_d;
  act_e              act_q, act_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  // Only the low ADDR_W bits of the 24-bit SPI address are kept; upper bits shift out.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              mem_rd_q, mem_rd_d;
  logic              load_q, load_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              fast_q, fast_d;
  logic              wrote_q, wrote_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic              wel_q, wel_d;
  logic              wip_q, wip_d;
  logic [WipW-1:0]   wip_cnt_q, wip_cnt_d;

  logic [7:0] rx_byte;
  logic       byte_done;
  logic [7:0] id_byte;
  logic [7:0] status_byte;

  assign rx_byte     = {rx_q, mosi_s};
  assign byte_done   = sck_rise && (bit_cnt_q == 3'd7);
  assign status_byte = {6'b0, wel_q, wip_q};

  always_comb begin
    unique case (id_idx_q)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    mem_rd_d   = 1'b0;
    load_d     = mem_rd_q;
    mem_wr_d   = 1'b0;
    wdata_d    = wdata_q;
    fast_d     = fast_q;
    wrote_d    = wrote_q;
    id_idx_d   = id_idx_q;
    wel_d      = wel_q;
    wip_d      = wip_q;
    wip_cnt_d  = wip_cnt_q;

    if (wip_q) begin
      if (wip_cnt_q == '0) begin
        wip_d = 1'b0;
      end else begin
        wip_cnt_d = wip_cnt_q - 1'b1;
      end
    end

    // Post-increment after the write strobe so mem_addr is stable during it.
    if (mem_wr_q) begin
      addr_d[7:0] = addr_q[7:0] + 8'd1;
    end

    // Read data arrives one clk after mem_rd; well ahead of the next SCK fall.
    if (load_q) begin
      tx_d = mem_rdata;
    end

    if (cs_n_s) begin
      state_d    = StIdle;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
      miso_d     = 1'b0;
      if (cs_rise) begin
        unique case (act_q)
          ActWren: wel_d = 1'b1;
          ActWrdi: wel_d = 1'b0;
          ActPp: begin
            if (wrote_q) begin
              wel_d     = 1'b0;
              wip_d     = 1'b1;
              wip_cnt_d = WipLoad;
            end
          end
          default: ;
        endcase
      end
      act_d   = ActNone;
      wrote_d = 1'b0;
    end else begin
      if (sck_rise && (state_q != StIdle)) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (sck_fall && is_tx_state(state_q)) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end

      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d = StCmd;
          end
        end
        StCmd: begin
          if (byte_done) begin
            fast_d   = 1'b0;
            id_idx_d = 2'd0;
            state_d  = StIgnore;
            if (wip_q) begin
              // Only status and ID are served while programming.
              if (rx_byte == OpRdsr) begin
                state_d = StStatus;
                tx_d    = status_byte;
              end else if (rx_byte == OpRdid) begin
                state_d  = StId;
                tx_d     = JEDEC_ID[23:16];
                id_idx_d = 2'd1;
              end
            end else begin
              case (rx_byte)
                OpWren: act_d = ActWren;
                OpWrdi: act_d = ActWrdi;
                OpRdsr: begin
                  state_d = StStatus;
                  tx_d    = status_byte;
                end
                OpRdid: begin
                  state_d  = StId;
                  tx_d     = JEDEC_ID[23:16];
                  id_idx_d = 2'd1;
                end
                OpRead: state_d = StAddr;
                OpFastRead: begin
                  state_d = StAddr;
                  fast_d  = 1'b1;
                end
                OpPp: begin
                  if (wel_q) begin
                    state_d = StAddr;
                    act_d   = ActPp;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            addr_d = {addr_q[ADDR_W-2:0], mosi_s};
          end
          if (byte_done) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd2) begin
              byte_cnt_d = 2'd0;
              if (act_q == ActPp) begin
                state_d = StDataWr;
              end else if (fast_q) begin
                state_d = StDummy;
              end else begin
                state_d  = StDataRd;
                mem_rd_d = 1'b1;
              end
            end
          end
        end
        StDummy: begin
          if (byte_done) begin
            state_d  = StDataRd;
            mem_rd_d = 1'b1;
          end
        end
        StDataRd: begin
          if (byte_done) begin
            addr_d   = addr_q + 1'b1;
            mem_rd_d = 1'b1;
          end
        end
        StDataWr: begin
          if (byte_done) begin
            mem_wr_d = 1'b1;
            wdata_d  = rx_byte;
            wrote_d  = 1'b1;
          end
        end
        StStatus: begin
          if (byte_done) begin
            tx_d = status_byte;
          end
        end
        StId: begin
          if (byte_done) begin
            tx_d = id_byte;
            if (id_idx_q != 2'd3) begin
              id_idx_d = id_idx_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      act_q      <= ActNone;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      load_q     <= 1'b0;
      mem_wr_q   <= 1'b0;
      wdata_q    <= '0;
      fast_q     <= 1'b0;
      wrote_q    <= 1'b0;
      id_idx_q   <= '0;
      wel_q      <= 1'b0;
      wip_q      <= 1'b0;
      wip_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      mem_rd_q   <= mem_rd_d;
      load_q     <= load_d;
      mem_wr_q   <= mem_wr_d;
      wdata_q    <= wdata_d;
      fast_q     <= fast_d;
      wrote_q    <= wrote_d;
      id_idx_q   <= id_idx_d;
      wel_q      <= wel_d;
      wip_q      <= wip_d;
      wip_cnt_q  <= wip_cnt_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = is_tx_state(state_q) & ~cs_n_s;
  assign mem_addr    = addr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_wdata   = wdata_q;
  assign wel         = wel_q;
  assign wip         = wip_q;

endmodule
